axis_in_port: RTL and testbench

AXI4-Stream video slave for the write side of the VDMA, the counterpart of the output port. Accepts pixel beats framed by tuser (start of frame) and tlast (end of line), checks them against the programmed geometry, and pushes pixels into the write FIFO. Alongside each FIFO write it emits frame, line and end-of-frame alignment markers for the downstream write-address logic. Malformed lines and frames are flagged and recovered at defined points.

---
 rtl/axis_in_port_if.sv | 13 +
 rtl/axis_in_port.sv | 161 ++++++++++++++++
 tb/tb_axis_in_port.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_in_port_if.sv
// AXI4-Stream video beat bundle between a pixel source and axis_in_port.
interface axis_in_port_if #(
    parameter int DSIZE = 24
);
    logic [DSIZE-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tuser;
    logic             tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_in_port.sv
// AXI4-Stream video slave for the VDMA write side: geometry check, FIFO write, alignment markers.
// Define AXIS_IN_PAD_EN to pad short lines with zeros instead of abandoning the frame.
module axis_in_port #(
    parameter int DSIZE = 24
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [15:0]      vactive,
    input  logic [15:0]      hactive,
    axis_in_port_if.slave    s,
    input  logic             fifo_afull,
    output logic             wr_en,
    output logic [DSIZE-1:0] wr_data,
    output logic             falign,
    output logic             lalign,
    output logic             ealign,
    output logic             err_early_eol,
    output logic             err_late_eol,
    output logic             err_sof,
    output logic             busy
);

`ifdef AXIS_IN_PAD_EN
    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DISCARD, PAD} state_t;
`else
    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DISCARD} state_t;
`endif

    state_t      state;
    logic [15:0] hcnt;
    logic [15:0] vcnt;
    logic [15:0] hmax;
    logic [15:0] vmax;
    logic        accept;
    logic        take;
    logic [15:0] h_eff;
    logic [15:0] v_eff;
    logic        last_line;

    assign hmax   = hactive - 16'd1;
    assign vmax   = vactive - 16'd1;
    assign busy   = (state != WAIT_SOF);
    assign accept = s.tvalid & s.tready;

    always_comb begin
        s.tready = 1'b1;
        unique case (state)
            WAIT_SOF: s.tready = 1'b1;
            ACTIVE:   s.tready = ~fifo_afull;
            DISCARD:  s.tready = 1'b1;
`ifdef AXIS_IN_PAD_EN
            PAD:      s.tready = 1'b0;
`endif
            default:  s.tready = 1'b1;
        endcase
    end

    // A tuser beat restarts the frame, so its position is evaluated as (0,0) before the tlast rules.
    always_comb begin
        take = accept & (((state == WAIT_SOF) & s.tuser & enable) |
                         (state == ACTIVE) |
                         ((state == DISCARD) & s.tuser));
        h_eff     = s.tuser ? '0 : hcnt;
        v_eff     = s.tuser ? '0 : vcnt;
        last_line = (v_eff == vmax);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_SOF;
            hcnt          <= '0;
            vcnt          <= '0;
            wr_en         <= 1'b0;
            wr_data       <= '0;
            falign        <= 1'b0;
            lalign        <= 1'b0;
            ealign        <= 1'b0;
            err_early_eol <= 1'b0;
            err_late_eol  <= 1'b0;
            err_sof       <= 1'b0;
        end else begin
            wr_en         <= 1'b0;
            falign        <= 1'b0;
            lalign        <= 1'b0;
            ealign        <= 1'b0;
            err_early_eol <= 1'b0;
            err_late_eol  <= 1'b0;
            err_sof       <= 1'b0;
            if (take) begin
                wr_en   <= 1'b1;
                wr_data <= s.tdata;
                falign  <= s.tuser;
                lalign  <= (h_eff == '0);
                err_sof <= s.tuser & (state != WAIT_SOF) & ~((hcnt == '0) & (vcnt == '0));
                if (s.tlast && (h_eff < hmax)) begin
                    err_early_eol <= 1'b1;
`ifdef AXIS_IN_PAD_EN
                    hcnt  <= h_eff + 16'd1;
                    vcnt  <= v_eff;
                    state <= PAD;
`else
                    hcnt  <= '0;
                    vcnt  <= '0;
                    state <= WAIT_SOF;
`endif
                end else if (h_eff >= hmax) begin
                    err_late_eol <= ~s.tlast;
                    if (last_line) begin
                        ealign <= 1'b1;
                        hcnt   <= '0;
                        vcnt   <= '0;
                        state  <= WAIT_SOF;
                    end else if (s.tlast) begin
                        hcnt  <= '0;
                        vcnt  <= v_eff + 16'd1;
                        state <= ACTIVE;
                    end else begin
                        hcnt  <= h_eff;
                        vcnt  <= v_eff;
                        state <= DISCARD;
                    end
                end else begin
                    hcnt  <= h_eff + 16'd1;
                    vcnt  <= v_eff;
                    state <= ACTIVE;
                end
            end else if ((state == DISCARD) && accept && s.tlast) begin
                hcnt <= '0;
                if (vcnt == vmax) begin
                    vcnt  <= '0;
                    state <= WAIT_SOF;
                end else begin
                    vcnt  <= vcnt + 16'd1;
                    state <= ACTIVE;
                end
            end
`ifdef AXIS_IN_PAD_EN
            else if ((state == PAD) && !fifo_afull) begin
                wr_en   <= 1'b1;
                wr_data <= '0;
                lalign  <= (hcnt == '0);
                if (hcnt >= hmax) begin
                    hcnt <= '0;
                    if (vcnt == vmax) begin
                        ealign <= 1'b1;
                        vcnt   <= '0;
                        state  <= WAIT_SOF;
                    end else begin
                        vcnt  <= vcnt + 16'd1;
                        state <= ACTIVE;
                    end
                end else begin
                    hcnt <= hcnt + 16'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_axis_in_port.sv
// Scoreboard bench for axis_in_port with hactive=4, vactive=3.
module tb_axis_in_port;
    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        fifo_afull = 1'b0;
    logic [15:0] vactive = 16'd3;
    logic [15:0] hactive = 16'd4;
    logic        wr_en;
    logic [23:0] wr_data;
    logic        falign, lalign, ealign;
    logic        err_early_eol, err_late_eol, err_sof, busy;

    axis_in_port_if #(.DSIZE(24)) s ();

    axis_in_port #(.DSIZE(24)) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .enable        (enable),
        .vactive       (vactive),
        .hactive       (hactive),
        .s             (s),
        .fifo_afull    (fifo_afull),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .falign        (falign),
        .lalign        (lalign),
        .ealign        (ealign),
        .err_early_eol (err_early_eol),
        .err_late_eol  (err_late_eol),
        .err_sof       (err_sof),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [23:0] d;
        logic f, l, e, ee, el, es;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_e;
    wr_t act_e;
    int  checks = 0;
    int  errors = 0;

    function automatic void push(input logic [23:0] d, input logic f, l, e, ee, el, es);
        wr_t w;
        w = {d, f, l, e, ee, el, es};
        exp_q.push_back(w);
    endfunction

    function automatic logic [23:0] px(input logic [7:0] t, input int unsigned ln, input int unsigned p);
        logic [7:0] lb, pb;
        lb = ln[7:0];
        pb = p[7:0];
        return {t, lb, pb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clock) begin
        if (rst_n) begin
            if (wr_en) begin
                checks++;
                act_e = {wr_data, falign, lalign, ealign, err_early_eol, err_late_eol, err_sof};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %h (data,f,l,e,ee,el,es) expected no write", act_e);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (act_e !== exp_e) begin
                        errors++;
                        $display("FAIL write: got %h expected %h (data,f,l,e,ee,el,es)", act_e, exp_e);
                    end
                end
            end else if (falign | lalign | ealign | err_early_eol | err_late_eol | err_sof) begin
                checks++;
                errors++;
                $display("FAIL stray_flag: got f%b l%b e%b ee%b el%b es%b expected all 0 without wr_en",
                         falign, lalign, ealign, err_early_eol, err_late_eol, err_sof);
            end
        end
    end

    task automatic beat(input logic [23:0] d, input logic u, input logic l);
        bit acc;
        acc = 1'b0;
        s.tdata  = d;
        s.tuser  = u;
        s.tlast  = l;
        s.tvalid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clock);
            acc = s.tready;
            @(posedge clock);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no handshake expected accept of %h", d);
        end
        s.tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] tag, input bit push_en, input bit sof_err);
        for (int unsigned ln = 0; ln < 3; ln++)
            for (int unsigned p = 0; p < 4; p++) begin
                if (push_en)
                    push(px(tag, ln, p), ln == 0 && p == 0, p == 0, ln == 2 && p == 3,
                         1'b0, 1'b0, sof_err && ln == 0 && p == 0);
                beat(px(tag, ln, p), ln == 0 && p == 0, p == 3);
            end
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clock);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        s.tvalid = 1'b0;
        s.tuser  = 1'b0;
        s.tlast  = 1'b0;
        s.tdata  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_markers", {falign, lalign, ealign}, 0);
        chk("rst_errors", {err_early_eol, err_late_eol, err_sof}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tready", s.tready, 1);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        // Clean frame, continuous valid.
        send_frame(8'h01, 1'b1, 1'b0);
        chk("clean_busy_after", busy, 0);
        drain("clean_drain");

        // Same frame with 5 cycles of FIFO back-pressure in line 1.
        fork
            send_frame(8'h02, 1'b1, 1'b0);
            begin
                repeat (6) @(posedge clock);
                #1;
                fifo_afull = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clock);
                    chk("afull_tready_low", s.tready, 0);
                    chk("afull_busy", busy, 1);
                end
                @(posedge clock);
                #1;
                fifo_afull = 1'b0;
                @(negedge clock);
                chk("afull_tready_back", s.tready, 1);
            end
        join
        drain("afull_drain");

        // Early tlast on pixel 2 of line 1.
        for (int unsigned p = 0; p < 4; p++) begin
            push(px(8'h03, 0, p), p == 0, p == 0, 1'b0, 1'b0, 1'b0, 1'b0);
            beat(px(8'h03, 0, p), p == 0, p == 3);
        end
        push(px(8'h03, 1, 0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(px(8'h03, 1, 0), 1'b0, 1'b0);
        push(px(8'h03, 1, 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(px(8'h03, 1, 1), 1'b0, 1'b1);
`ifdef AXIS_IN_PAD_EN
        push(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int unsigned p = 0; p < 4; p++)
            push(px(8'h03, 2, p), 1'b0, p == 0, p == 3, 1'b0, 1'b0, 1'b0);
`endif
        for (int unsigned p = 0; p < 4; p++)
            beat(px(8'h03, 2, p), 1'b0, p == 3);
        drain("early_drain");
        chk("early_busy_after", busy, 0);

        // Line 0 runs 6 beats: pixels 4-5 dropped, rest of frame aligns.
        for (int unsigned p = 0; p < 6; p++) begin
            if (p < 4)
                push(px(8'h04, 0, p), p == 0, p == 0, 1'b0, 1'b0, p == 3, 1'b0);
            beat(px(8'h04, 0, p), p == 0, p == 5);
        end
        for (int unsigned ln = 1; ln < 3; ln++)
            for (int unsigned p = 0; p < 4; p++) begin
                push(px(8'h04, ln, p), 1'b0, p == 0, ln == 2 && p == 3, 1'b0, 1'b0, 1'b0);
                beat(px(8'h04, ln, p), 1'b0, p == 3);
            end
        drain("late_drain");
        chk("late_busy_after", busy, 0);

        // tuser on pixel 3 of line 2 restarts the frame.
        for (int unsigned ln = 0; ln < 3; ln++)
            for (int unsigned p = 0; p < 4; p++)
                if (ln < 2 || p < 2) begin
                    push(px(8'h05, ln, p), ln == 0 && p == 0, p == 0, 1'b0, 1'b0, 1'b0, 1'b0);
                    beat(px(8'h05, ln, p), ln == 0 && p == 0, p == 3);
                end
        send_frame(8'h06, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        drain("sof_drain");

        // Capture disabled at SOF.
        enable = 1'b0;
        send_frame(8'h08, 1'b0, 1'b0);
        chk("disabled_busy", busy, 0);
        drain("disabled_drain");
        enable = 1'b1;

        // Reset mid-frame.
        for (int unsigned p = 0; p < 5; p++) begin
            push(px(8'h09, p / 4, p % 4), p == 0, p % 4 == 0, 1'b0, 1'b0, 1'b0, 1'b0);
            beat(px(8'h09, p / 4, p % 4), p == 0, p == 3);
        end
        drain("prereset_drain");
        chk("prereset_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clock);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tready", s.tready, 1);
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        for (int unsigned p = 1; p < 4; p++)
            beat(px(8'h09, 1, p), 1'b0, p == 3);
        chk("postrst_busy", busy, 0);
        send_frame(8'h0a, 1'b1, 1'b0);
        drain("postrst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
